mem_wb_pipe: RTL and testbench
==============================

# mem_wb_pipe

Memory-access stage plus MEM/WB pipeline register for the LA32R five-stage core, with the data SRAM read latency set by a parameter. It issues loads and stores to the data SRAM, generates byte lanes, aligns and sign-extends load data, and flags misaligned accesses. It exposes the forwarding/bypass view of the MEM stage and holds a valid-qualified WB register. Back-pressure is a valid/allow-in handshake in both directions.

## Interface
- RD_LAT, 1, cycles from the read-request cycle to valid `data_sram_rdata` (1..4)
- RESET_PC, 32'h1c000000, reset value of `wb_pc`
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush  in  1  kill the instruction in MEM (exception/branch redirect)
- to_ms_valid  in  1  EX holds a valid instruction
- ms_allow_in  out  1  MEM accepts at this edge
- ex_pc  in  32  instruction PC
- ex_ld / ex_st  in  1 / 1  load / store instruction
- ex_mem_op  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (stores use [1:0])
- ex_addr  in  32  effective address
- ex_st_data  in  32  store source register
- ex_rf_we  in  1  writes a GPR
- ex_rf_waddr  in  5  destination register
- ex_alu_res  in  32  non-load write-back value
- data_sram_en  out  1  access request
- data_sram_we  out  4  byte write enables
- data_sram_addr  out  32  {ex_addr[31:2],2'b00}
- data_sram_wdata  out  32  lane-replicated store data
- data_sram_rdata  in  32  read data
- wb_allow_in  in  1  WB accepts at this edge
- ms_fwd_we  out  1  MEM has a valid GPR write
- ms_fwd_addr  out  5  its destination
- ms_fwd_ok  out  1  ms_fwd_data is final (0 while a load is pending)
- ms_fwd_data  out  32  forwarded value
- wb_valid, wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata, wb_ale  out  1,32,1,5,32,1  WB register contents

## Operation
- MEM register (pc, ld, st, op, addr, st_data, rf_we, rf_waddr, alu_res, ms_valid) loads at an edge with `ms_allow_in`. ms_valid <= to_ms_valid.
- `ms_allow_in = !ms_valid || (ms_ready_go && wb_allow_in)`. Forced 0 in DRAIN.
- Misaligned access (`ale`): H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - No SRAM access is made.
  - rf_we is forced 0 into WB.
  - wb_ale=1.
- Store byte enables and write data:
  - B: we = 4'b0001<<addr[1:0], wdata = {4{d[7:0]}}.
  - H: we = 4'b0011<<{addr[1],1'b0}, wdata = {2{d[15:0]}}.
  - W: we = 4'b1111, wdata = d.
- Load: select the byte or half at addr[1:0]. B/H sign-extend; BU/HU zero-extend.
- FSM:
  - IDLE: on a valid, aligned ld/st, assert data_sram_en for exactly this cycle. A load goes to WAIT with cnt=1. A store or other instruction is ready immediately.
  - WAIT: cnt increments each cycle. When cnt==RD_LAT, capture aligned data into hold_q and go to DONE. ms_ready_go=1 in the capture cycle, and the data passes through combinationally.
  - DONE: ms_ready_go=1, data comes from hold_q. On transfer to WB → IDLE.
  - DRAIN: entered on flush while in WAIT. Stay until cnt==RD_LAT, discard the data, then → IDLE.
- flush: ms_valid <= 0 at the next edge and no new request is issued that cycle. From WAIT → DRAIN; from any other state → IDLE.
- Forwarding:
  - ms_fwd_we = ms_valid && rf_we && !ale.
  - ms_fwd_ok = !ld || ms_ready_go.
  - ms_fwd_data = load result or alu_res.
- WB register: on ms_ready_go && wb_allow_in, wb_valid <= ms_valid && !flush, and the other wb_* fields load. Otherwise wb_valid <= 0 if wb_allow_in, else hold.

## Timing
- Reset state:
  - ms_valid=0, FSM=IDLE, cnt=0, hold_q=0.
  - wb_valid=0, wb_pc=RESET_PC, all other wb_* = 0.
  - data_sram_en=0, data_sram_we=0.
- Load entering MEM at cycle T:
  - Request in T.
  - ms_ready_go in T+RD_LAT.
  - Earliest wb_valid at T+RD_LAT+1.
- Store/ALU op entering at T: ready in T, wb_valid at T+1.
- Throughput: one ALU/store per cycle; one load per RD_LAT+1 cycles.
- WB stall (wb_allow_in=0) in DONE: hold_q is stable. No new SRAM request issues until MEM empties.
- All SRAM outputs are gated by ms_valid. data_sram_we=0 for loads and for misaligned stores.
- reset overrides flush and stall.

## Test plan
- ALU op, rf_waddr=5, alu_res=0x1234 → wb_valid=1, wb_rf_wdata=0x1234 one cycle later; ms_fwd_ok=1 in MEM.
- st.h addr=0x..02, data=0xAABBCCDD → we=4'b1100, wdata=0xCCDDCCDD, addr low bits 00.
- RD_LAT=3, ld.b addr=0x..03, rdata=0x80FFFFFF → ms_fwd_ok=0 for 3 cycles, then wb_rf_wdata=0xFFFFFF80. ld.bu on the same data → 0x00000080.
- ld.w addr=0x..01 → data_sram_en=0, wb_ale=1, wb_rf_we=0, one-cycle latency.
- RD_LAT=2, load then wb_allow_in=0 for 5 cycles → data held in hold_q, ms_allow_in=0, single write-back of the correct value on release.
- flush one cycle after a load request, RD_LAT=3 → DRAIN for 2 cycles with ms_allow_in=0, no wb_valid, then a new load completes normally.

Source files
------------

// File: rtl/mem_wb_pipe_if.sv
// rtl/mem_wb_pipe_if.sv - EX-to-MEM handshake and instruction payload
interface mem_wb_pipe_if;
  logic        to_ms_valid;
  logic        ms_allow_in;
  logic [31:0] ex_pc;
  logic        ex_ld;
  logic        ex_st;
  logic [2:0]  ex_mem_op;
  logic [31:0] ex_addr;
  logic [31:0] ex_st_data;
  logic        ex_rf_we;
  logic [4:0]  ex_rf_waddr;
  logic [31:0] ex_alu_res;

  modport master (
    output to_ms_valid, ex_pc, ex_ld, ex_st, ex_mem_op, ex_addr, ex_st_data,
           ex_rf_we, ex_rf_waddr, ex_alu_res,
    input  ms_allow_in
  );

  modport slave (
    input  to_ms_valid, ex_pc, ex_ld, ex_st, ex_mem_op, ex_addr, ex_st_data,
           ex_rf_we, ex_rf_waddr, ex_alu_res,
    output ms_allow_in
  );
endinterface

// File: rtl/mem_wb_pipe.sv
// rtl/mem_wb_pipe.sv - LA32R memory-access stage with MEM/WB pipeline register
module mem_wb_pipe #(
  parameter int          RD_LAT   = 1,
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  mem_wb_pipe_if.slave      ex,
  output logic              data_sram_en,
  output logic [3:0]        data_sram_we,
  output logic [31:0]       data_sram_addr,
  output logic [31:0]       data_sram_wdata,
  input  logic [31:0]       data_sram_rdata,
  input  logic              wb_allow_in,
  output logic              ms_fwd_we,
  output logic [4:0]        ms_fwd_addr,
  output logic              ms_fwd_ok,
  output logic [31:0]       ms_fwd_data,
  output logic              wb_valid,
  output logic [31:0]       wb_pc,
  output logic              wb_rf_we,
  output logic [4:0]        wb_rf_waddr,
  output logic [31:0]       wb_rf_wdata,
  output logic              wb_ale
);

  localparam logic [2:0] LAT = 3'(RD_LAT);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, DRAIN} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [31:0] hold_q;

  logic        ms_valid;
  logic        sent_q;
  logic [31:0] pc_q;
  logic        ld_q;
  logic        st_q;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] st_data_q;
  logic        rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] alu_res_q;

  logic        mem_acc;
  logic        ale;
  logic        lat_hit;
  logic        ms_ready_go;
  logic        ms_allow_in;
  logic        to_wb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_aligned;
  logic [31:0] ld_result;
  logic [31:0] fwd_data;
  logic [3:0]  st_we;
  logic [31:0] st_wdata;

  always_comb begin
    mem_acc = ld_q || st_q;
    case (op_q[1:0])
      2'b01:   ale = mem_acc && addr_q[0];
      2'b10:   ale = mem_acc && (addr_q[1:0] != 2'b00);
      default: ale = 1'b0;
    endcase

    ld_byte = data_sram_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
    case (op_q)
      3'b000:  ld_aligned = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_aligned = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_aligned = {24'd0, ld_byte};
      3'b101:  ld_aligned = {16'd0, ld_half};
      default: ld_aligned = data_sram_rdata;
    endcase

    case (op_q[1:0])
      2'b00: begin
        st_we    = 4'b0001 << addr_q[1:0];
        st_wdata = {4{st_data_q[7:0]}};
      end
      2'b01: begin
        st_we    = 4'b0011 << {addr_q[1], 1'b0};
        st_wdata = {2{st_data_q[15:0]}};
      end
      default: begin
        st_we    = 4'b1111;
        st_wdata = st_data_q;
      end
    endcase

    lat_hit = (cnt == LAT);
    case (state)
      IDLE:    ms_ready_go = !(ms_valid && ld_q && !ale);
      WAIT:    ms_ready_go = lat_hit;
      DONE:    ms_ready_go = 1'b1;
      default: ms_ready_go = 1'b0;
    endcase

    // Load data bypasses hold_q in the capture cycle so WB can take it at once.
    ld_result   = (state == DONE) ? hold_q : ld_aligned;
    fwd_data    = (ld_q && !ale) ? ld_result : alu_res_q;
    ms_allow_in = (state != DRAIN) && (!ms_valid || (ms_ready_go && wb_allow_in));
    to_wb       = ms_ready_go && wb_allow_in;

    // sent_q keeps a stalled store from rewriting the SRAM every cycle.
    data_sram_en    = ms_valid && (state == IDLE) && mem_acc && !ale && !sent_q && !flush;
    data_sram_we    = (data_sram_en && st_q) ? st_we : 4'b0000;
    data_sram_addr  = ms_valid ? {addr_q[31:2], 2'b00} : 32'd0;
    data_sram_wdata = ms_valid ? st_wdata : 32'd0;
  end

  assign ex.ms_allow_in = ms_allow_in;
  assign ms_fwd_we      = ms_valid && rf_we_q && !ale;
  assign ms_fwd_addr    = rf_waddr_q;
  assign ms_fwd_ok      = !ld_q || ms_ready_go;
  assign ms_fwd_data    = fwd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid   <= 1'b0;
      sent_q     <= 1'b0;
      pc_q       <= 32'd0;
      ld_q       <= 1'b0;
      st_q       <= 1'b0;
      op_q       <= 3'd0;
      addr_q     <= 32'd0;
      st_data_q  <= 32'd0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      alu_res_q  <= 32'd0;
    end else begin
      if (ms_allow_in) begin
        pc_q       <= ex.ex_pc;
        ld_q       <= ex.ex_ld;
        st_q       <= ex.ex_st;
        op_q       <= ex.ex_mem_op;
        addr_q     <= ex.ex_addr;
        st_data_q  <= ex.ex_st_data;
        rf_we_q    <= ex.ex_rf_we;
        rf_waddr_q <= ex.ex_rf_waddr;
        alu_res_q  <= ex.ex_alu_res;
        sent_q     <= 1'b0;
      end else if (data_sram_en) begin
        sent_q <= 1'b1;
      end
      if (flush) begin
        ms_valid <= 1'b0;
      end else if (ms_allow_in) begin
        ms_valid <= ex.to_ms_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      hold_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (data_sram_en && ld_q) begin
            state <= WAIT;
            cnt   <= 3'd1;
          end
        end
        WAIT: begin
          if (lat_hit) begin
            hold_q <= ld_aligned;
            cnt    <= 3'd0;
            state  <= (flush || wb_allow_in) ? IDLE : DONE;
          end else begin
            cnt <= cnt + 3'd1;
            if (flush) state <= DRAIN;
          end
        end
        DONE: begin
          if (flush || wb_allow_in) state <= IDLE;
        end
        default: begin
          // The killed load's read data still has to arrive before the SRAM is reusable.
          if (lat_hit) begin
            state <= IDLE;
            cnt   <= 3'd0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid    <= 1'b0;
      wb_pc       <= RESET_PC;
      wb_rf_we    <= 1'b0;
      wb_rf_waddr <= 5'd0;
      wb_rf_wdata <= 32'd0;
      wb_ale      <= 1'b0;
    end else if (to_wb) begin
      wb_valid <= ms_valid && !flush;
      if (ms_valid) begin
        wb_pc       <= pc_q;
        wb_rf_we    <= rf_we_q && !ale;
        wb_rf_waddr <= rf_waddr_q;
        wb_rf_wdata <= fwd_data;
        wb_ale      <= ale;
      end
    end else if (wb_allow_in) begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb/tb_mem_wb_pipe.sv - scoreboard bench for mem_wb_pipe with a fixed-latency SRAM model
module tb_mem_wb_pipe;
  localparam int RD_LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        wb_allow_in;
  logic        ms_fwd_we;
  logic [4:0]  ms_fwd_addr;
  logic        ms_fwd_ok;
  logic [31:0] ms_fwd_data;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_rf_we;
  logic [4:0]  wb_rf_waddr;
  logic [31:0] wb_rf_wdata;
  logic        wb_ale;

  mem_wb_pipe_if ex_if ();

  mem_wb_pipe #(.RD_LAT(RD_LAT), .RESET_PC(32'h1c000000)) dut (
    .clk(clk), .reset(reset), .flush(flush), .ex(ex_if),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .wb_allow_in(wb_allow_in),
    .ms_fwd_we(ms_fwd_we), .ms_fwd_addr(ms_fwd_addr), .ms_fwd_ok(ms_fwd_ok),
    .ms_fwd_data(ms_fwd_data), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata),
    .wb_ale(wb_ale)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        ale;
    bit          chk_wdata;
  } wb_exp_t;

  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_wdata;
  } sram_exp_t;

  wb_exp_t   wb_q[$];
  sram_exp_t sram_q[$];
  wb_exp_t   we_item;
  sram_exp_t se_item;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: read data is valid exactly RD_LAT cycles after the request, garbage otherwise.
  logic [31:0]       mem [16];
  logic [RD_LAT-1:0] rv;
  logic [3:0]        ra [RD_LAT];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
      mem[0] <= 32'h80FFFFFF;
      mem[1] <= 32'h11223344;
      rv <= '0;
    end else begin
      rv    <= {rv[RD_LAT-2:0], data_sram_en && (data_sram_we == 4'b0000)};
      ra[0] <= data_sram_addr[5:2];
      for (int i = 1; i < RD_LAT; i++) ra[i] <= ra[i-1];
      if (data_sram_en)
        for (int b = 0; b < 4; b++)
          if (data_sram_we[b]) mem[data_sram_addr[5:2]][8*b +: 8] <= data_sram_wdata[8*b +: 8];
    end
  end

  assign data_sram_rdata = rv[RD_LAT-1] ? mem[ra[RD_LAT-1]] : 32'hDEADBEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (data_sram_en) begin
        if (sram_q.size() == 0) begin
          n_checks++;
          $display("FAIL sram_unexpected: got request addr %h we %b, required none", data_sram_addr, data_sram_we);
        end else begin
          se_item = sram_q.pop_front();
          check("sram_we", 32'(data_sram_we), 32'(se_item.we));
          check("sram_addr", data_sram_addr, se_item.addr);
          if (se_item.chk_wdata) check("sram_wdata", data_sram_wdata, se_item.wdata);
        end
      end
      if (wb_valid && wb_allow_in) begin
        if (wb_q.size() == 0) begin
          n_checks++;
          $display("FAIL wb_unexpected: got write-back pc %h, required none", wb_pc);
        end else begin
          we_item = wb_q.pop_front();
          check("wb_pc", wb_pc, we_item.pc);
          check("wb_rf_we", 32'(wb_rf_we), 32'(we_item.rf_we));
          check("wb_rf_waddr", 32'(wb_rf_waddr), 32'(we_item.waddr));
          check("wb_ale", 32'(wb_ale), 32'(we_item.ale));
          if (we_item.chk_wdata) check("wb_rf_wdata", wb_rf_wdata, we_item.wdata);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_wb(input logic [31:0] pc, input logic rf_we, input logic [4:0] waddr,
                        input logic [31:0] wdata, input logic ale, input bit chk);
    wb_q.push_back('{pc: pc, rf_we: rf_we, waddr: waddr, wdata: wdata, ale: ale, chk_wdata: chk});
  endtask

  task automatic exp_sram(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit chk);
    sram_q.push_back('{we: we, addr: addr, wdata: wdata, chk_wdata: chk});
  endtask

  task automatic send(input logic [31:0] pc, input logic ld, input logic st, input logic [2:0] op,
                      input logic [31:0] addr, input logic [31:0] sd, input logic rf_we,
                      input logic [4:0] waddr, input logic [31:0] alu);
    bit acc = 1'b0;
    ex_if.to_ms_valid = 1'b1;
    ex_if.ex_pc       = pc;
    ex_if.ex_ld       = ld;
    ex_if.ex_st       = st;
    ex_if.ex_mem_op   = op;
    ex_if.ex_addr     = addr;
    ex_if.ex_st_data  = sd;
    ex_if.ex_rf_we    = rf_we;
    ex_if.ex_rf_waddr = waddr;
    ex_if.ex_alu_res  = alu;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = ex_if.ms_allow_in;
      step();
    end
    if (!acc) begin
      n_checks++;
      $display("FAIL send_timeout: got no ms_allow_in for pc %h within 50 cycles, required acceptance", pc);
    end
    ex_if.to_ms_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000, required finish");
    $fatal(1);
  end

  initial begin
    int t0;
    reset             = 1'b1;
    flush             = 1'b0;
    wb_allow_in       = 1'b1;
    ex_if.to_ms_valid = 1'b0;
    ex_if.ex_pc       = 32'd0;
    ex_if.ex_ld       = 1'b0;
    ex_if.ex_st       = 1'b0;
    ex_if.ex_mem_op   = 3'd0;
    ex_if.ex_addr     = 32'd0;
    ex_if.ex_st_data  = 32'd0;
    ex_if.ex_rf_we    = 1'b0;
    ex_if.ex_rf_waddr = 5'd0;
    ex_if.ex_alu_res  = 32'd0;
    repeat (3) step();
    @(negedge clk);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_pc", wb_pc, 32'h1c000000);
    check("rst_wb_rf_we", 32'(wb_rf_we), 32'd0);
    check("rst_wb_rf_wdata", wb_rf_wdata, 32'd0);
    check("rst_wb_ale", 32'(wb_ale), 32'd0);
    check("rst_sram_en", 32'(data_sram_en), 32'd0);
    check("rst_sram_we", 32'(data_sram_we), 32'd0);
    check("rst_allow_in", 32'(ex_if.ms_allow_in), 32'd1);
    step();
    reset = 1'b0;
    step();

    // ALU op forwards immediately and reaches WB one cycle later.
    exp_wb(32'h1c000000, 1'b1, 5'd5, 32'h1234, 1'b0, 1'b1);
    send(32'h1c000000, 0, 0, 3'b000, 32'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
    @(negedge clk);
    check("alu_fwd_ok", 32'(ms_fwd_ok), 32'd1);
    check("alu_fwd_we", 32'(ms_fwd_we), 32'd1);
    check("alu_fwd_addr", 32'(ms_fwd_addr), 32'd5);
    check("alu_fwd_data", ms_fwd_data, 32'h1234);
    check("alu_no_sram", 32'(data_sram_en), 32'd0);
    step();
    @(negedge clk);
    check("alu_wb_valid_t1", 32'(wb_valid), 32'd1);
    step();

    // Three ALU ops back to back: one per cycle.
    t0 = cyc;
    exp_wb(32'h1c000010, 1'b1, 5'd1, 32'h11, 1'b0, 1'b1);
    exp_wb(32'h1c000014, 1'b1, 5'd2, 32'h22, 1'b0, 1'b1);
    exp_wb(32'h1c000018, 1'b1, 5'd3, 32'h33, 1'b0, 1'b1);
    send(32'h1c000010, 0, 0, 3'b000, 32'd0, 32'd0, 1'b1, 5'd1, 32'h11);
    send(32'h1c000014, 0, 0, 3'b000, 32'd0, 32'd0, 1'b1, 5'd2, 32'h22);
    send(32'h1c000018, 0, 0, 3'b000, 32'd0, 32'd0, 1'b1, 5'd3, 32'h33);
    check("alu_throughput_cycles", 32'(cyc - t0), 32'd3);

    // Stores: st.h at offset 2 and st.b at offset 3.
    exp_sram(4'b1100, 32'h00000104, 32'hCCDDCCDD, 1'b1);
    exp_wb(32'h1c000020, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    send(32'h1c000020, 0, 1, 3'b001, 32'h00000106, 32'hAABBCCDD, 1'b0, 5'd0, 32'd0);
    exp_sram(4'b1000, 32'h00000108, 32'h55555555, 1'b1);
    exp_wb(32'h1c000024, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    send(32'h1c000024, 0, 1, 3'b000, 32'h0000010B, 32'h12345655, 1'b0, 5'd0, 32'd0);

    // ld.b with RD_LAT=3: forward not ready for three cycles.
    exp_sram(4'b0000, 32'h00000100, 32'd0, 1'b0);
    exp_wb(32'h1c000030, 1'b1, 5'd7, 32'hFFFFFF80, 1'b0, 1'b1);
    send(32'h1c000030, 1, 0, 3'b000, 32'h00000103, 32'd0, 1'b1, 5'd7, 32'd0);
    for (int i = 0; i < RD_LAT; i++) begin
      @(negedge clk);
      check("ldb_fwd_ok_pending", 32'(ms_fwd_ok), 32'd0);
      check("ldb_allow_in_pending", 32'(ex_if.ms_allow_in), 32'd0);
      step();
    end
    @(negedge clk);
    check("ldb_fwd_ok_final", 32'(ms_fwd_ok), 32'd1);
    check("ldb_fwd_data", ms_fwd_data, 32'hFFFFFF80);
    step();
    @(negedge clk);
    check("ldb_wb_valid", 32'(wb_valid), 32'd1);
    step();

    exp_sram(4'b0000, 32'h00000100, 32'd0, 1'b0);
    exp_wb(32'h1c000034, 1'b1, 5'd8, 32'h00000080, 1'b0, 1'b1);
    send(32'h1c000034, 1, 0, 3'b100, 32'h00000103, 32'd0, 1'b1, 5'd8, 32'd0);
    exp_sram(4'b0000, 32'h00000104, 32'd0, 1'b0);
    exp_wb(32'h1c000038, 1'b1, 5'd9, 32'h0000CCDD, 1'b0, 1'b1);
    send(32'h1c000038, 1, 0, 3'b101, 32'h00000106, 32'd0, 1'b1, 5'd9, 32'd0);
    exp_sram(4'b0000, 32'h00000100, 32'd0, 1'b0);
    exp_wb(32'h1c00003c, 1'b1, 5'd10, 32'hFFFF80FF, 1'b0, 1'b1);
    send(32'h1c00003c, 1, 0, 3'b001, 32'h00000102, 32'd0, 1'b1, 5'd10, 32'd0);
    exp_sram(4'b0000, 32'h00000108, 32'd0, 1'b0);
    exp_wb(32'h1c000040, 1'b1, 5'd11, 32'h55000000, 1'b0, 1'b1);
    send(32'h1c000040, 1, 0, 3'b010, 32'h00000108, 32'd0, 1'b1, 5'd11, 32'd0);
    repeat (RD_LAT + 2) step();

    // Misaligned ld.w and st.w: no SRAM access, ale flagged, one-cycle latency.
    exp_wb(32'h1c000050, 1'b0, 5'd9, 32'd0, 1'b1, 1'b0);
    send(32'h1c000050, 1, 0, 3'b010, 32'h00000101, 32'd0, 1'b1, 5'd9, 32'd0);
    @(negedge clk);
    check("ale_ld_no_sram", 32'(data_sram_en), 32'd0);
    check("ale_ld_fwd_we", 32'(ms_fwd_we), 32'd0);
    step();
    @(negedge clk);
    check("ale_ld_wb_valid", 32'(wb_valid), 32'd1);
    exp_wb(32'h1c000054, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    step();
    send(32'h1c000054, 0, 1, 3'b010, 32'h00000102, 32'h99999999, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("ale_st_no_sram", 32'(data_sram_en), 32'd0);
    check("ale_st_no_we", 32'(data_sram_we), 32'd0);
    step();
    step();

    // WB stall around a load: value held, MEM blocked, single write-back on release.
    exp_sram(4'b0000, 32'h00000104, 32'd0, 1'b0);
    exp_wb(32'h1c000060, 1'b1, 5'd10, 32'hCCDD3344, 1'b0, 1'b1);
    send(32'h1c000060, 1, 0, 3'b010, 32'h00000104, 32'd0, 1'b1, 5'd10, 32'd0);
    wb_allow_in = 1'b0;
    repeat (RD_LAT) step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_allow_in", 32'(ex_if.ms_allow_in), 32'd0);
      check("stall_fwd_data", ms_fwd_data, 32'hCCDD3344);
      check("stall_no_sram", 32'(data_sram_en), 32'd0);
      step();
    end
    wb_allow_in = 1'b1;
    step();
    @(negedge clk);
    check("stall_wb_valid", 32'(wb_valid), 32'd1);
    step();
    @(negedge clk);
    check("stall_single_wb", 32'(wb_valid), 32'd0);
    step();

    // Flush one cycle after a load request: drain, no write-back, then a clean load.
    exp_sram(4'b0000, 32'h00000100, 32'd0, 1'b0);
    send(32'h1c000070, 1, 0, 3'b010, 32'h00000100, 32'd0, 1'b1, 5'd11, 32'd0);
    @(negedge clk);
    check("flush_req_issued", 32'(data_sram_en), 32'd1);
    step();
    flush = 1'b1;
    @(negedge clk);
    check("flush_allow_in_t1", 32'(ex_if.ms_allow_in), 32'd0);
    step();
    flush = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      @(negedge clk);
      check("drain_allow_in", 32'(ex_if.ms_allow_in), 32'd0);
      check("drain_no_wb", 32'(wb_valid), 32'd0);
      step();
    end
    @(negedge clk);
    check("drain_done_allow_in", 32'(ex_if.ms_allow_in), 32'd1);
    check("drain_done_no_wb", 32'(wb_valid), 32'd0);
    exp_sram(4'b0000, 32'h00000108, 32'd0, 1'b0);
    exp_wb(32'h1c000074, 1'b1, 5'd12, 32'h55000000, 1'b0, 1'b1);
    step();
    send(32'h1c000074, 1, 0, 3'b010, 32'h00000108, 32'd0, 1'b1, 5'd12, 32'd0);

    repeat (10) step();
    check("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    check("sram_queue_drained", 32'(sram_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
